decimal_entry_controller: RTL and testbench
===========================================

// Module: decimal_entry_controller
// PURPOSE
//  - Player-side decimal input path, the inverse of the 7-seg output path.
//  - Three push buttons edit a 3-digit decimal number (hundreds/tens/ones).
//  - The block holds the per-digit BCD values, a digit cursor, and on ENTER converts BCD->8-bit binary.
//  - The binary result goes to game logic; the BCD digits and cursor feed the 7-seg path for echo.
// PARAMETERS
//  - DEBOUNCE_CYCLES  16  stable-high/low cycles required before a button level is accepted (only with debounce enabled)
// PORTS
//  - clk          in   1  system clock; single clock domain
//  - rst          in   1  synchronous, active-high reset
//  - btn_inc      in   1  async button: increment digit under cursor
//  - btn_next     in   1  async button: move cursor hundreds->tens->ones->hundreds
//  - btn_enter    in   1  async button: commit the entered number
//  - hundreds     out  4  BCD hundreds digit, 0..2
//  - tens         out  4  BCD tens digit, 0..9
//  - ones         out  4  BCD ones digit, 0..9
//  - cursor       out  2  0=hundreds, 1=tens, 2=ones (same encoding as display digit state); 3 never driven
//  - value_out    out  8  last successfully committed binary value
//  - value_valid  out  1  one-cycle pulse when value_out updates
//  - overflow     out  1  one-cycle pulse when ENTER was rejected (number > 255)
// BEHAVIOUR
//  - Reset values: all outputs 0; digits 0; cursor 0; FSM in EDIT_H.
//  - Button path, per button:
//    - 2-flop synchronizer, then rising-edge detect -> 1-cycle internal strobe.
//    - A held button produces exactly one strobe; no auto-repeat.
//  - Latency: the FSM acts on the 3rd rising clk edge after a button is first sampled high.
//    - Without debounce: 2 sync stages + 1 edge-detect register.
//    - With debounce: add DEBOUNCE_CYCLES.
//  - FSM states: EDIT_H, EDIT_T, EDIT_O, COMMIT; cursor = 0/1/2 in EDIT_H/T/O.
//    - next strobe: EDIT_H->EDIT_T->EDIT_O->EDIT_H (wrap).
//    - inc strobe: digit under cursor +1.
//      - Hundreds wraps 2->0.
//      - Tens and ones wrap 9->0.
//      - No carry between digits.
//    - enter strobe, any EDIT state: go to COMMIT for exactly 1 cycle.
//  - In the COMMIT cycle, compute sum = hundreds*100 + tens*10 + ones as a 9-bit unsigned value (max 299).
//    - sum <= 255: value_out <= sum[7:0] and value_valid = 1 on the next cycle.
//    - sum > 255: value_out is unchanged, overflow = 1 on the next cycle, value_valid stays 0.
//    - Both cases: digits clear to 0, cursor -> 0, FSM -> EDIT_H.
//    - Pulses are high in the cycle after COMMIT, then drop.
//  - Simultaneous strobes in one cycle: enter > next > inc; lower-priority strobes are discarded, not queued.
//  - Strobes arriving while in COMMIT are discarded.
//  - value_valid and overflow are mutually exclusive, never asserted two cycles in a row.
//  - Reset mid-operation (including during COMMIT):
//    - All state returns to reset values on the next edge.
//    - Synchronizer and edge registers also clear.
//    - A button held through reset release gives one strobe, since the post-reset level 0 -> 1 counts as an edge.
// CONFIGURATION
//  - Macro DECIMAL_ENTRY_DEBOUNCE_EN.
//  - Defined: each synchronized button passes a counter filter.
//    - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples at the new level.
//    - The counter is wide enough for DEBOUNCE_CYCLES.
//    - Bounces shorter than DEBOUNCE_CYCLES yield no strobe.
//  - Undefined: no filter; the synchronized level feeds edge detect directly; DEBOUNCE_CYCLES is ignored.
// STRUCTURE
//  - Shared header decimal_entry_defs.vh, include-guarded like the other shared files:
//    - FSM state localparams (EDIT_H=0, EDIT_T=1, EDIT_O=2, COMMIT=3).
//    - Digit max constants (HUND_MAX=2, DIGIT_MAX=9).
//    - BCD width (4).
//  - Sub-module button_edge_detector, instantiated 3x.
//    - Contents: synchronizer, optional debounce filter, rising-edge strobe.
//    - Ports: clk, rst, btn_in, strobe.
//  - Top level holds the FSM, digit registers, BCD->binary adder (shift-add constant multiply) and output registers.
// TESTING
//  - Compile and run the bench both with and without DECIMAL_ENTRY_DEBOUNCE_EN.
//  - Reset: assert rst 2 cycles with buttons idle -> all outputs 0, cursor=0.
//  - Entry: inc x1, next, inc x2, next, inc x5, enter (digits 1,2,5) -> single value_valid pulse; value_out=125; digits and cursor back to 0.
//  - Wrap: inc x3 on hundreds -> hundreds=0; next, inc x10 -> tens=0; next x3 from hundreds -> cursor=0.
//  - Overflow: enter 2,5,6 -> overflow pulse, value_valid=0, value_out keeps prior 125.
//  - Boundary: enter 2,5,5 -> value_out=255; enter 0,0,0 -> value_out=0 with a valid pulse.
//  - Priority and hold: next and enter rise in the same cycle on 1,0,0 -> commit 100, cursor stays 0.
//  - Hold: inc held 50 cycles -> digit +1 only.
//  - Debounce (macro defined): 3 bounce pulses of 5 cycles each, then a stable high, with DEBOUNCE_CYCLES=16 -> exactly one strobe, 16+3 cycles after the stable level.

Source files
------------

// File: rtl/decimal_entry_controller_pkg.sv
// Shared definitions for the decimal entry path: FSM state encoding,
// digit limits, BCD width and the BCD -> binary helper.
// Optional debounce filter is controlled by macro DECIMAL_ENTRY_DEBOUNCE_EN.
`ifndef DECIMAL_ENTRY_CONTROLLER_PKG_SV
`define DECIMAL_ENTRY_CONTROLLER_PKG_SV

package decimal_entry_controller_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] HUND_MAX  = 4'd2;
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

    // Cursor value equals the state code in the three edit states.
    typedef enum logic [1:0] {
        EDIT_H = 2'd0,
        EDIT_T = 2'd1,
        EDIT_O = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // hundreds*100 + tens*10 + ones with shift-add constant multiplies.
    // 100 = 64 + 32 + 4, 10 = 8 + 2; result fits 9 bits (max 299).
    function automatic logic [8:0] bcd_to_bin(input logic [BCD_W-1:0] h,
                                              input logic [BCD_W-1:0] t,
                                              input logic [BCD_W-1:0] o);
        logic [8:0] hh;
        logic [8:0] tt;
        logic [8:0] oo;
        hh = {5'b0, h};
        tt = {5'b0, t};
        oo = {5'b0, o};
        return (hh << 6) + (hh << 5) + (hh << 2) + (tt << 3) + (tt << 1) + oo;
    endfunction

endpackage

`endif

// File: rtl/decimal_entry_controller_button_edge_detector.sv
// Per-button conditioning: 2-flop synchronizer, optional counter debounce
// filter (macro DECIMAL_ENTRY_DEBOUNCE_EN), and a rising-edge one-cycle strobe.
// The strobe is combinational from the level and its registered copy, so the
// consumer acts on the 3rd clock edge after the button is first sampled high
// (plus DEBOUNCE_CYCLES edges when the filter is compiled in).
module button_edge_detector
`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic strobe
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive samples at it;
    // any sample back at the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync2 != filt) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Previous level for rising-edge detection; cleared by reset so a button
    // held through reset release still yields one strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign strobe = level & ~level_q;

endmodule

// File: rtl/decimal_entry_controller.sv
// Decimal entry controller: three buttons edit a 3-digit BCD number under a
// cursor; ENTER converts to 8-bit binary, rejecting values above 255.
// Optional button debounce is controlled by macro DECIMAL_ENTRY_DEBOUNCE_EN.
module decimal_entry_controller
`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_enter,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] cursor,
    output logic [7:0] value_out,
    output logic       value_valid,
    output logic       overflow
);

    import decimal_entry_controller_pkg::*;

    logic inc_stb;
    logic next_stb;
    logic enter_stb;

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    button_edge_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn_in(btn_inc), .strobe(inc_stb)
    );
    button_edge_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .btn_in(btn_next), .strobe(next_stb)
    );
    button_edge_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .btn_in(btn_enter), .strobe(enter_stb)
    );
`else
    button_edge_detector u_inc (
        .clk(clk), .rst(rst), .btn_in(btn_inc), .strobe(inc_stb)
    );
    button_edge_detector u_next (
        .clk(clk), .rst(rst), .btn_in(btn_next), .strobe(next_stb)
    );
    button_edge_detector u_enter (
        .clk(clk), .rst(rst), .btn_in(btn_enter), .strobe(enter_stb)
    );
`endif

    state_t           state_q, state_d;
    logic [BCD_W-1:0] hund_q, hund_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic [7:0]       value_q, value_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [8:0]       sum;

    assign sum = bcd_to_bin(hund_q, tens_q, ones_q);

    // State, digit and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EDIT_H;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            value_q <= value_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and digit edits; enter beats next beats inc, and strobes
    // seen during COMMIT are dropped.
    always_comb begin
        state_d = state_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        value_d = value_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            COMMIT: begin
                if (sum <= 9'd255) begin
                    value_d = sum[7:0];
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                hund_d  = '0;
                tens_d  = '0;
                ones_d  = '0;
                state_d = EDIT_H;
            end
            default: begin
                if (enter_stb) begin
                    state_d = COMMIT;
                end else if (next_stb) begin
                    case (state_q)
                        EDIT_H:  state_d = EDIT_T;
                        EDIT_T:  state_d = EDIT_O;
                        default: state_d = EDIT_H;
                    endcase
                end else if (inc_stb) begin
                    case (state_q)
                        EDIT_H:  hund_d = (hund_q == HUND_MAX)  ? '0 : hund_q + 4'd1;
                        EDIT_T:  tens_d = (tens_q == DIGIT_MAX) ? '0 : tens_q + 4'd1;
                        default: ones_d = (ones_q == DIGIT_MAX) ? '0 : ones_q + 4'd1;
                    endcase
                end
            end
        endcase
    end

    // Cursor decode: state code in edit states, hundreds during COMMIT.
    always_comb begin
        cursor = 2'd0;
        case (state_q)
            EDIT_T:  cursor = 2'd1;
            EDIT_O:  cursor = 2'd2;
            default: cursor = 2'd0;
        endcase
    end

    assign hundreds    = hund_q;
    assign tens        = tens_q;
    assign ones        = ones_q;
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_decimal_entry_controller.sv
// Bench for decimal_entry_controller: directed button sequences, a behavioural
// model of the entry rules checked every cycle, and literal expectations.
// Build with or without DECIMAL_ENTRY_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_decimal_entry_controller;

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    localparam int DB  = 16;
    localparam int LAT = 18;
`else
    localparam int DB  = 1;
    localparam int LAT = 2;
`endif
    localparam int HI = LAT + 4;
    localparam int LO = LAT + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_enter = 1'b0;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] cursor;
    logic [7:0] value_out;
    logic       value_valid;
    logic       overflow;

    // Clock and reset block
    always #5 clk = ~clk;

    decimal_entry_controller dut (
        .clk(clk), .rst(rst),
        .btn_inc(btn_inc), .btn_next(btn_next), .btn_enter(btn_enter),
        .hundreds(hundreds), .tens(tens), .ones(ones), .cursor(cursor),
        .value_out(value_out), .value_valid(value_valid), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: button levels delayed through the conditioning path,
    // then the entry rules applied to whatever strobes emerge.
    bit m_h1[3], m_h2[3], m_acc[3], m_accp[3], m_s[3], m_b[3];
    int m_run[3];
    int m_dig[3];
    int m_cur;
    bit m_commit;
    int m_val;
    bit m_valid, m_ovf;
    int m_sum;

    always @(posedge clk) begin
        m_b[0] = btn_inc;
        m_b[1] = btn_next;
        m_b[2] = btn_enter;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_h1[i] = 0; m_h2[i] = 0; m_acc[i] = 0; m_accp[i] = 0; m_run[i] = 0;
                m_dig[i] = 0;
            end
            m_cur = 0; m_commit = 0; m_val = 0; m_valid = 0; m_ovf = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_s[i] = m_acc[i] & ~m_accp[i];
                m_accp[i] = m_acc[i];
                if (DB == 1) begin
                    m_acc[i] = m_h1[i];
                end else if (m_h2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_acc[i] = m_h2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_h2[i] = m_h1[i];
                m_h1[i] = m_b[i];
            end
            m_valid = 0;
            m_ovf = 0;
            if (m_commit) begin
                m_sum = m_dig[0] * 100 + m_dig[1] * 10 + m_dig[2];
                if (m_sum <= 255) begin
                    m_val = m_sum;
                    m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
                m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
                m_cur = 0;
                m_commit = 0;
            end else if (m_s[2]) begin
                m_commit = 1;
            end else if (m_s[1]) begin
                m_cur = (m_cur + 1) % 3;
            end else if (m_s[0]) begin
                m_dig[m_cur] = (m_dig[m_cur] + 1) % ((m_cur == 0) ? 3 : 10);
            end
        end
    end

    // Scoreboard: compare DUT against the model on every falling edge.
    int valid_cnt = 0;
    int ovf_cnt = 0;

    always @(negedge clk) begin
        chk("hundreds", int'(hundreds), m_dig[0]);
        chk("tens", int'(tens), m_dig[1]);
        chk("ones", int'(ones), m_dig[2]);
        if (!m_commit) chk("cursor", int'(cursor), m_cur);
        chk("value_out", int'(value_out), m_val);
        chk("value_valid", int'(value_valid), int'(m_valid));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (value_valid) valid_cnt++;
        if (overflow) ovf_cnt++;
    end

    // Driver tasks
    task automatic set_btn(input int idx, input logic lvl);
        case (idx)
            0: btn_inc = lvl;
            1: btn_next = lvl;
            default: btn_enter = lvl;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        repeat (HI) @(negedge clk);
        set_btn(idx, 1'b0);
        repeat (LO) @(negedge clk);
    endtask

    task automatic enter_num(input int h, input int t, input int o);
        repeat (h) press(0);
        press(1);
        repeat (t) press(0);
        press(1);
        repeat (o) press(0);
        press(2);
    endtask

    int v0, o0;

    initial begin
        // Reset held for two cycles with buttons idle
        repeat (2) @(negedge clk);
        chk("rst_hundreds", int'(hundreds), 0);
        chk("rst_tens", int'(tens), 0);
        chk("rst_ones", int'(ones), 0);
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_value", int'(value_out), 0);
        chk("rst_valid", int'(value_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Entry 1,2,5
        v0 = valid_cnt;
        enter_num(1, 2, 5);
        chk("entry_pulses", valid_cnt - v0, 1);
        chk("entry_value", int'(value_out), 125);
        chk("entry_clear", int'({hundreds, tens, ones}), 0);
        chk("entry_cursor", int'(cursor), 0);

        // Wrap behaviour
        repeat (3) press(0);
        chk("wrap_hundreds", int'(hundreds), 0);
        press(1);
        repeat (10) press(0);
        chk("wrap_tens", int'(tens), 0);
        chk("wrap_cursor_t", int'(cursor), 1);
        press(1);
        press(1);
        repeat (3) press(1);
        chk("wrap_cursor", int'(cursor), 0);

        // Overflow 2,5,6 keeps prior value
        v0 = valid_cnt;
        o0 = ovf_cnt;
        enter_num(2, 5, 6);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        chk("ovf_no_valid", valid_cnt - v0, 0);
        chk("ovf_value_kept", int'(value_out), 125);
        chk("ovf_clear", int'({hundreds, tens, ones}), 0);

        // Boundaries 255 and 0
        v0 = valid_cnt;
        enter_num(2, 5, 5);
        chk("max_value", int'(value_out), 255);
        chk("max_pulses", valid_cnt - v0, 1);
        v0 = valid_cnt;
        enter_num(0, 0, 0);
        chk("zero_value", int'(value_out), 0);
        chk("zero_pulses", valid_cnt - v0, 1);

        // next and enter rise together on 1,0,0
        press(0);
        v0 = valid_cnt;
        btn_next = 1'b1;
        btn_enter = 1'b1;
        repeat (HI) @(negedge clk);
        btn_next = 1'b0;
        btn_enter = 1'b0;
        repeat (LO) @(negedge clk);
        chk("prio_value", int'(value_out), 100);
        chk("prio_cursor", int'(cursor), 0);
        chk("prio_pulses", valid_cnt - v0, 1);

        // Held inc gives a single increment
        btn_inc = 1'b1;
        repeat (50) @(negedge clk);
        btn_inc = 1'b0;
        repeat (LO) @(negedge clk);
        chk("hold_hundreds", int'(hundreds), 1);

        // Strobe latency from first high sample
        btn_inc = 1'b1;
        repeat (LAT) @(negedge clk);
        chk("lat_before", int'(hundreds), 1);
        @(negedge clk);
        chk("lat_at", int'(hundreds), 2);
        btn_inc = 1'b0;
        repeat (LO) @(negedge clk);

        // Reset during COMMIT, enter held through reset release
        v0 = valid_cnt;
        btn_enter = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_value", int'(value_out), 0);
        chk("midrst_hundreds", int'(hundreds), 0);
        chk("midrst_valid", int'(value_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (HI) @(negedge clk);
        btn_enter = 1'b0;
        repeat (LO) @(negedge clk);
        chk("held_rst_pulses", valid_cnt - v0, 1);
        chk("held_rst_value", int'(value_out), 0);

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
        // Three 5-cycle bounces, then a stable high
        repeat (3) begin
            btn_inc = 1'b1;
            repeat (5) @(negedge clk);
            btn_inc = 1'b0;
            repeat (5) @(negedge clk);
        end
        chk("bounce_none", int'(hundreds), 0);
        btn_inc = 1'b1;
        repeat (LAT) @(negedge clk);
        chk("db_before", int'(hundreds), 0);
        @(negedge clk);
        chk("db_at", int'(hundreds), 1);
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (LO) @(negedge clk);
        chk("db_once", int'(hundreds), 1);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
